// File: rtl/riscv_v_wb_queue_if.sv
// Vector writeback queue types and ALU-result / RF-write-port interface.
// Master is the environment side (ALU + RF), slave is the queue.
package riscv_v_wb_pkg;
   localparam int RISCV_V_RF_ADDR_WIDTH  = 5;
   localparam int RISCV_V_DATA_WIDTH     = 128;
   localparam int RISCV_V_NUM_BYTES_DATA = 16;

   typedef logic [RISCV_V_RF_ADDR_WIDTH-1:0]  riscv_v_rf_addr_t;
   typedef logic [RISCV_V_DATA_WIDTH-1:0]     riscv_v_data_t;
   typedef logic [RISCV_V_NUM_BYTES_DATA-1:0] riscv_v_rf_wr_en_t;

   typedef struct packed {
      riscv_v_rf_addr_t  addr;
      riscv_v_data_t     data;
      riscv_v_rf_wr_en_t bytes;
   } riscv_v_wb_data_t;
endpackage

interface riscv_v_wb_queue_if;
   import riscv_v_wb_pkg::*;

   logic              in_valid;
   logic              in_ready;
   riscv_v_rf_addr_t  in_addr;
   riscv_v_data_t     in_data;
   riscv_v_rf_wr_en_t in_bytes;
   logic              rf_wr_stall;
   riscv_v_rf_wr_en_t rf_wr_en;
   riscv_v_rf_addr_t  rf_wr_addr;
   riscv_v_data_t     rf_wr_data;

   modport master (
      output in_valid, in_addr, in_data, in_bytes, rf_wr_stall,
      input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data
   );

   modport slave (
      input  in_valid, in_addr, in_data, in_bytes, rf_wr_stall,
      output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data
   );
endinterface

// File: rtl/riscv_v_wb_queue.sv
// In-order vector writeback queue with same-register coalescing and hazard report.
// Optional zero-latency cut-through when RISCV_V_WB_BYPASS_EN is defined.
module riscv_v_wb_queue
   import riscv_v_wb_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter bit COALESCE = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   riscv_v_wb_queue_if.slave      wb,
   input  riscv_v_rf_addr_t       hz_addr_a,
   input  riscv_v_rf_addr_t       hz_addr_b,
   output logic                   hz_pend_a,
   output logic                   hz_pend_b,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

   typedef logic [PW-1:0] ptr_t;

   riscv_v_wb_data_t mem [DEPTH];
   logic [DEPTH-1:0] vld;
   ptr_t             rd_ptr;
   ptr_t             wr_ptr;
   ptr_t             yng;

   logic             full;
   logic             pop;
   logic             accept;
   logic             coal;
   logic             push;
   logic             byp;
   riscv_v_wb_data_t head;
   riscv_v_wb_data_t merged;
   logic [PW:0]      count_nxt;

   assign full        = (count == CNT_FULL);
   assign wb.in_ready = !full;
   assign yng         = wr_ptr - 1'b1;
   assign head        = mem[rd_ptr];
   assign pop         = !empty && !wb.rf_wr_stall;
   assign accept      = wb.in_valid && !full && (|wb.in_bytes);

`ifdef RISCV_V_WB_BYPASS_EN
   assign byp = rst_n && empty && wb.in_valid
              && (|wb.in_bytes) && !wb.rf_wr_stall;
`else
   assign byp = 1'b0;
`endif

   // A single entry that pops this cycle must not absorb a new write.
   assign coal = accept && COALESCE && !empty
               && (wb.in_addr == mem[yng].addr)
               && !(pop && count == CNT_ONE);
   assign push = accept && !coal && !byp;

   always_comb begin
      merged       = mem[yng];
      merged.bytes = mem[yng].bytes | wb.in_bytes;
      for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++) begin
         if (wb.in_bytes[i]) begin
            merged.data[8*i +: 8] = wb.in_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      wb.rf_wr_en   = empty ? '0 : head.bytes;
      wb.rf_wr_addr = head.addr;
      wb.rf_wr_data = head.data;
      if (byp) begin
         wb.rf_wr_en   = wb.in_bytes;
         wb.rf_wr_addr = wb.in_addr;
         wb.rf_wr_data = wb.in_data;
      end
   end

   always_comb begin
      hz_pend_a = 1'b0;
      hz_pend_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i] && mem[i].addr == hz_addr_a) hz_pend_a = 1'b1;
         if (vld[i] && mem[i].addr == hz_addr_b) hz_pend_b = 1'b1;
      end
      if (byp && wb.in_addr == hz_addr_a) hz_pend_a = 1'b1;
      if (byp && wb.in_addr == hz_addr_b) hz_pend_b = 1'b1;
   end

   always_comb begin
      count_nxt = count;
      unique case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         vld    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (coal) mem[yng] <= merged;
         if (push) begin
            mem[wr_ptr] <= '{addr:  wb.in_addr,
                             data:  wb.in_data,
                             bytes: wb.in_bytes};
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + 1'b1;
         end
         count <= count_nxt;
         empty <= (count_nxt == '0);
      end
   end

   a_no_push_full: assert property (
      @(posedge clk) disable iff (!rst_n) !(push && full));

   a_count_max: assert property (
      @(posedge clk) disable iff (!rst_n) count <= CNT_FULL);

   // Head contents only move under stall when a write merges into it.
   a_stall_stable: assert property (
      @(posedge clk) disable iff (!rst_n)
      (wb.rf_wr_stall && !empty && !coal) |=>
      ($stable(wb.rf_wr_en) && $stable(wb.rf_wr_addr)
       && $stable(wb.rf_wr_data)));

endmodule
